fsr_direction_ctrl: RTL and testbench
=====================================

Name: fsr_direction_ctrl

Overview:
- Parametrised successor to the fixed-period FSR button controller.
- Produces left/right/neither direction flags in one of two modes:
  - auto-toggle demo mode: timed alternation;
  - sensor mode: two FSR channels (left, right) from the XADC sample stream, each passed through a hysteresis threshold and a debounce counter.
- Sits between the XADC front end and the game/display logic that consumes direction_cs and the flags.

Parameters:
- ADC_W, 12, sample width in bits.
- CNT_W, 24, width of the count output and period counter.
- PERIOD, 5000000, auto-mode toggle period in clocks; requires 2 <= PERIOD <= 2^CNT_W.
- DEBOUNCE, 100000, consecutive clocks a raw press state must persist before it is accepted; requires >= 1.
- TH_HI, 2048, press threshold (sample >= TH_HI means pressed).
- TH_LO, 1536, release threshold (sample < TH_LO means released); requires TH_LO <= TH_HI.

Ports:
- CLK100MHZ  in  1  system clock.
- RST_BTN  in  1  reset; asynchronous, active-high.
- mode  in  1  0 = auto-toggle, 1 = sensor.
- sample_valid  in  1  one-cycle strobe; sample_ch/sample_data are valid.
- sample_ch  in  1  0 = left FSR, 1 = right FSR.
- sample_data  in  ADC_W  unsigned conversion result.
- direction_cs  out  1  0 = left, 1 = right (last non-neither direction).
- left_flag  out  1  direction is left.
- right_flag  out  1  direction is right.
- neither_flag  out  1  no single direction.
- pressed  out  2  debounced press state; bit 0 = left, bit 1 = right.
- dir_change  out  1  one-cycle pulse when the flag triple changes.
- count  out  CNT_W  auto-mode period counter.

Behaviour:
- Reset values (asynchronous):
  - direction_cs=0, left_flag=0, right_flag=0, neither_flag=1;
  - pressed=00, dir_change=0, count=0;
  - raw states, debounce counters and the registered mode all 0.
- Flags are one-hot at all times, including reset.
- Hysteresis, applied to the addressed channel only, on the clock where sample_valid=1:
  - sample_data >= TH_HI: raw <= 1;
  - sample_data < TH_LO: raw <= 0;
  - otherwise raw holds.
  - Other clocks: raw holds.
- Debounce, per channel, every clock:
  - raw == pressed bit: counter <= 0.
  - Otherwise counter increments. When counter == DEBOUNCE-1 on a clock where raw still differs, the pressed bit <= raw and the counter <= 0.
  - Latency: the pressed bit changes DEBOUNCE clocks after raw changes.
  - A raw glitch shorter than DEBOUNCE clocks never reaches pressed.
- Sensor mode (mode_q=1), flags registered from pressed with 1 clock latency:
  - 01: left=1, direction_cs<=0.
  - 10: right=1, direction_cs<=1.
  - 00 or 11: neither=1, direction_cs holds.
  - count held at 0.
- Auto mode (mode_q=0):
  - count increments every clock.
  - When count == PERIOD-1: count <= 0; direction_cs <= ~direction_cs; flags <= left if the old direction_cs==0, else right. Flags are neither only from reset/mode change until the first wrap.
  - Hysteresis and debounce keep running; pressed stays live.
- Mode change:
  - mode is registered into mode_q.
  - On the clock mode_q changes: count <= 0, flags <= neither, direction_cs holds.
  - The new-mode rules apply from the following clock.
- dir_change:
  - Registered; equals 1 on the clock after any flag output changed value.
  - Not asserted by reset release.
- Simultaneous events: sample_valid on one channel never disturbs the other channel's raw state, counter or pressed bit.
- Reset mid-operation clears everything immediately; no partial period completes.

Test Plan (PERIOD=8, DEBOUNCE=4, TH_HI=2048, TH_LO=1536, CNT_W=24):
- Auto mode, mode=0 from reset:
  - count runs 0..7 and wraps to 0;
  - first wrap gives left=1, direction_cs=1;
  - second wrap 8 clocks later gives right=1, direction_cs=0;
  - dir_change pulses once per wrap.
- Sensor press, mode=1:
  - ch0 sample 3000 -> pressed[0]=1 exactly 4 clocks after raw sets;
  - left_flag=1 one clock later.
  - ch0 sample 1800 -> no change (hysteresis band).
  - ch0 sample 1000 -> pressed[0]=0 after 4 clocks, then neither=1.
- Glitch rejection:
  - ch1 sample 4000, then ch1 sample 100 two clocks later;
  - pressed[1] stays 0; flags and dir_change unchanged.
- Both pressed:
  - ch0=3000 and ch1=3000 debounced -> neither=1;
  - direction_cs holds its prior value;
  - releasing ch0 -> right=1, direction_cs=1.
- Mode switch mid-period:
  - with count=5 in auto mode, set mode=1 -> count=0 and neither=1 on the mode_q-change clock;
  - back to mode=0 -> count restarts from 0.
- Asynchronous reset:
  - assert RST_BTN between clock edges with right=1 and count=6;
  - outputs go to reset values before the next edge;
  - count resumes from 0 after release.

Source files
------------

// File: rtl/fsr_direction_ctrl.sv
// Direction controller: auto-toggle demo mode, or two FSR sensor channels with
// hysteresis thresholds and debounce, producing one-hot left/right/neither flags.
module fsr_direction_ctrl #(
  parameter int ADC_W    = 12,
  parameter int CNT_W    = 24,
  parameter int PERIOD   = 5000000,
  parameter int DEBOUNCE = 100000,
  parameter int TH_HI    = 2048,
  parameter int TH_LO    = 1536
) (
  input  logic             CLK100MHZ,
  input  logic             RST_BTN,
  input  logic             mode,
  input  logic             sample_valid,
  input  logic             sample_ch,
  input  logic [ADC_W-1:0] sample_data,
  output logic             direction_cs,
  output logic             left_flag,
  output logic             right_flag,
  output logic             neither_flag,
  output logic [1:0]       pressed,
  output logic             dir_change,
  output logic [CNT_W-1:0] count
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);
  localparam logic [DB_W-1:0]  LP_DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0]  LP_DB_ONE   = DB_W'(1);
  localparam logic [ADC_W-1:0] LP_TH_HI    = ADC_W'(TH_HI);
  localparam logic [ADC_W-1:0] LP_TH_LO    = ADC_W'(TH_LO);

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_SENSOR = 1'b1
  } mode_e;

  mode_e            r_mode_q;
  logic [1:0]       r_raw;
  logic [1:0]       r_pressed;
  logic [DB_W-1:0]  r_dbc [2];
  logic [CNT_W-1:0] r_count;
  logic             r_dir;
  logic             r_left;
  logic             r_right;
  logic             r_neither;
  logic             r_dir_change;

  logic             w_mode_chg;
  logic [CNT_W-1:0] w_nxt_count;
  logic             w_nxt_dir;
  logic             w_nxt_left;
  logic             w_nxt_right;
  logic             w_nxt_neither;

  assign w_mode_chg = (mode != r_mode_q);

  // Next flag/count state; a mode change forces neither for exactly one clock
  // before the new mode's rules take over.
  always_comb begin
    w_nxt_count   = r_count;
    w_nxt_dir     = r_dir;
    w_nxt_left    = r_left;
    w_nxt_right   = r_right;
    w_nxt_neither = r_neither;
    if (w_mode_chg) begin
      w_nxt_count   = '0;
      w_nxt_left    = 1'b0;
      w_nxt_right   = 1'b0;
      w_nxt_neither = 1'b1;
    end else if (r_mode_q == MODE_SENSOR) begin
      w_nxt_count   = '0;
      w_nxt_left    = 1'b0;
      w_nxt_right   = 1'b0;
      w_nxt_neither = 1'b0;
      case (r_pressed)
        2'b01: begin
          w_nxt_left = 1'b1;
          w_nxt_dir  = 1'b0;
        end
        2'b10: begin
          w_nxt_right = 1'b1;
          w_nxt_dir   = 1'b1;
        end
        default: w_nxt_neither = 1'b1;
      endcase
    end else if (r_count == LP_CNT_LAST) begin
      w_nxt_count   = '0;
      w_nxt_dir     = ~r_dir;
      w_nxt_left    = ~r_dir;
      w_nxt_right   = r_dir;
      w_nxt_neither = 1'b0;
    end else begin
      w_nxt_count = r_count + LP_CNT_ONE;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST_BTN) begin
    if (RST_BTN) begin
      r_mode_q     <= MODE_AUTO;
      r_count      <= '0;
      r_dir        <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_neither    <= 1'b1;
      r_dir_change <= 1'b0;
    end else begin
      r_mode_q     <= mode_e'(mode);
      r_count      <= w_nxt_count;
      r_dir        <= w_nxt_dir;
      r_left       <= w_nxt_left;
      r_right      <= w_nxt_right;
      r_neither    <= w_nxt_neither;
      r_dir_change <= ({w_nxt_left, w_nxt_right, w_nxt_neither} !=
                       {r_left, r_right, r_neither});
    end
  end

  // Per-channel hysteresis and debounce; debounce sees the raw state from the
  // previous clock, so pressed follows raw exactly DEBOUNCE clocks later.
  always_ff @(posedge CLK100MHZ or posedge RST_BTN) begin
    if (RST_BTN) begin
      r_raw     <= 2'b00;
      r_pressed <= 2'b00;
      r_dbc[0]  <= '0;
      r_dbc[1]  <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (sample_valid && (sample_ch == 1'(c))) begin
          if (sample_data >= LP_TH_HI) begin
            r_raw[c] <= 1'b1;
          end else if (sample_data < LP_TH_LO) begin
            r_raw[c] <= 1'b0;
          end
        end
        if (r_raw[c] == r_pressed[c]) begin
          r_dbc[c] <= '0;
        end else if (r_dbc[c] == LP_DB_LAST) begin
          r_pressed[c] <= r_raw[c];
          r_dbc[c]     <= '0;
        end else begin
          r_dbc[c] <= r_dbc[c] + LP_DB_ONE;
        end
      end
    end
  end

  assign direction_cs = r_dir;
  assign left_flag    = r_left;
  assign right_flag   = r_right;
  assign neither_flag = r_neither;
  assign pressed      = r_pressed;
  assign dir_change   = r_dir_change;
  assign count        = r_count;

endmodule

// File: tb/tb_fsr_direction_ctrl.sv
// Bench for fsr_direction_ctrl: directed scenarios plus random traffic, every
// output compared each clock against a behavioural model of the direction rules.
module tb_fsr_direction_ctrl;

  localparam int ADC_W    = 12;
  localparam int CNT_W    = 24;
  localparam int PERIOD   = 8;
  localparam int DEBOUNCE = 4;
  localparam int TH_HI    = 2048;
  localparam int TH_LO    = 1536;

  logic             clk;
  logic             rst;
  logic             mode;
  logic             sample_valid;
  logic             sample_ch;
  logic [ADC_W-1:0] sample_data;
  logic             direction_cs;
  logic             left_flag;
  logic             right_flag;
  logic             neither_flag;
  logic [1:0]       pressed;
  logic             dir_change;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state. m_flag: 0 = neither, 1 = left, 2 = right.
  int m_mode;
  int m_raw [2];
  int m_run [2];
  int m_pressed [2];
  int m_since;
  int m_flag;
  int m_dir;
  int m_dc;

  fsr_direction_ctrl #(
    .ADC_W(ADC_W), .CNT_W(CNT_W), .PERIOD(PERIOD), .DEBOUNCE(DEBOUNCE),
    .TH_HI(TH_HI), .TH_LO(TH_LO)
  ) dut (
    .CLK100MHZ   (clk),
    .RST_BTN     (rst),
    .mode        (mode),
    .sample_valid(sample_valid),
    .sample_ch   (sample_ch),
    .sample_data (sample_data),
    .direction_cs(direction_cs),
    .left_flag   (left_flag),
    .right_flag  (right_flag),
    .neither_flag(neither_flag),
    .pressed     (pressed),
    .dir_change  (dir_change),
    .count       (count)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_mode = 0;
    m_since = 0;
    m_flag = 0;
    m_dir = 0;
    m_dc = 0;
    for (int c = 0; c < 2; c++) begin
      m_raw[c] = 0;
      m_run[c] = 0;
      m_pressed[c] = 0;
    end
  endtask

  task automatic model_step();
    int old_flag;
    int pv;
    old_flag = m_flag;
    pv = m_pressed[0] + 2 * m_pressed[1];
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_since = 0;
      m_flag = 0;
    end else if (m_mode == 1) begin
      m_since = 0;
      if (pv == 1) begin
        m_flag = 1;
        m_dir = 0;
      end else if (pv == 2) begin
        m_flag = 2;
        m_dir = 1;
      end else begin
        m_flag = 0;
      end
    end else begin
      m_since++;
      if (m_since % PERIOD == 0) begin
        m_flag = (m_dir == 1) ? 2 : 1;
        m_dir = 1 - m_dir;
      end
    end
    m_dc = (m_flag != old_flag) ? 1 : 0;
    for (int c = 0; c < 2; c++) begin
      if (m_raw[c] != m_pressed[c]) begin
        m_run[c]++;
        if (m_run[c] == DEBOUNCE) begin
          m_pressed[c] = m_raw[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    if (sample_valid) begin
      if (int'(sample_data) >= TH_HI) m_raw[int'(sample_ch)] = 1;
      else if (int'(sample_data) < TH_LO) m_raw[int'(sample_ch)] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(m_since % PERIOD));
    check("direction_cs", 32'(direction_cs), 32'(m_dir));
    check("left_flag", 32'(left_flag), 32'(m_flag == 1));
    check("right_flag", 32'(right_flag), 32'(m_flag == 2));
    check("neither_flag", 32'(neither_flag), 32'(m_flag == 0));
    check("pressed", 32'(pressed), 32'(m_pressed[0] + 2 * m_pressed[1]));
    check("dir_change", 32'(dir_change), 32'(m_dc));
  endtask

  // Driver tasks: inputs change on the falling edge, outputs checked there too.
  task automatic cyc(input logic m, input logic v, input logic ch, input int d);
    mode = m;
    sample_valid = v;
    sample_ch = ch;
    sample_data = ADC_W'(d);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic m, input int n);
    for (int i = 0; i < n; i++) cyc(m, 1'b0, 1'b0, 0);
  endtask

  initial begin
    logic r_mode;
    int   found;
    mode = 1'b0;
    sample_valid = 1'b0;
    sample_ch = 1'b0;
    sample_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all();
    check("reset_neither", 32'(neither_flag), 32'd1);
    rst = 1'b0;

    // Auto mode: two full periods plus a bit
    idle(1'b0, 8);
    check("first_wrap_left", 32'(left_flag), 32'd1);
    check("first_wrap_dir", 32'(direction_cs), 32'd1);
    idle(1'b0, 8);
    check("second_wrap_right", 32'(right_flag), 32'd1);
    idle(1'b0, 3);

    // Sensor press / hysteresis / release
    idle(1'b1, 2);
    cyc(1'b1, 1'b1, 1'b0, 3000);
    idle(1'b1, 3);
    check("press_before_latency", 32'(pressed[0]), 32'd0);
    idle(1'b1, 1);
    check("press_at_latency", 32'(pressed[0]), 32'd1);
    idle(1'b1, 1);
    check("left_after_press", 32'(left_flag), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1800);
    idle(1'b1, 6);
    check("band_holds", 32'(pressed[0]), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1000);
    idle(1'b1, 6);
    check("release_neither", 32'(neither_flag), 32'd1);

    // Glitch on ch1
    cyc(1'b1, 1'b1, 1'b1, 4000);
    idle(1'b1, 1);
    cyc(1'b1, 1'b1, 1'b1, 100);
    idle(1'b1, 6);
    check("glitch_rejected", 32'(pressed[1]), 32'd0);

    // Both pressed, then release left
    cyc(1'b1, 1'b1, 1'b0, 3000);
    cyc(1'b1, 1'b1, 1'b1, 3000);
    idle(1'b1, 8);
    check("both_neither", 32'(neither_flag), 32'd1);
    check("both_dir_hold", 32'(direction_cs), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1000);
    idle(1'b1, 7);
    check("right_after_release", 32'(right_flag), 32'd1);
    check("right_dir", 32'(direction_cs), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 500);
    idle(1'b1, 7);

    // Mode switch mid-period
    idle(1'b0, 1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_since % PERIOD == 5) found = 1;
      else idle(1'b0, 1);
    end
    check("reach_count5", 32'(found), 32'd1);
    idle(1'b1, 1);
    check("modesw_count", 32'(count), 32'd0);
    check("modesw_neither", 32'(neither_flag), 32'd1);
    idle(1'b1, 2);
    idle(1'b0, 1);
    idle(1'b0, 2);
    check("auto_restart", 32'(count), 32'd2);

    // Asynchronous reset with right=1 and count=6
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (m_flag == 2 && m_since % PERIOD == 6) found = 1;
      else idle(1'b0, 1);
    end
    check("reach_rst_point", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all();
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_neither", 32'(neither_flag), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0, 3);
    check("post_rst_count", 32'(count), 32'd3);

    // Random traffic
    r_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      int region;
      int d;
      if ($urandom_range(0, 199) == 0) r_mode = ~r_mode;
      region = int'($urandom_range(0, 2));
      if (region == 0) d = int'($urandom_range(0, TH_LO - 1));
      else if (region == 1) d = int'($urandom_range(TH_LO, TH_HI - 1));
      else d = int'($urandom_range(TH_HI, 4095));
      if ($urandom_range(0, 5) == 0)
        cyc(r_mode, 1'b1, 1'($urandom_range(0, 1)), d);
      else
        idle(r_mode, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
